data_mem_arbiter: RTL

// - Shares the single-port byte-addressed data memory between the CPU load/store port and a debug/DMA burst port.
// - Sits between the core datapath and data_memory and drives its A, WD, WE and modeBU inputs.
// - CPU accesses are single-beat and zero-latency when granted; debug accesses are word bursts that hold the memory until complete.

---
 rtl/data_mem_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port data memory between the CPU
// load/store port and a word-burst debug/DMA port.
//   clk, rst                  clock, synchronous active-high reset
//   cpu_* / cpu_stall         single-beat CPU access, zero latency when granted
//   dbg_* / dbg_gnt..dbg_err  debug burst request, beat strobe, read data, status
//   mem_*                     drive data_memory A/WD/WE/modeBU, mem_rd is its RD
// Optional macro ARB_ROUND_ROBIN_EN: alternate CPU/debug when both request in
// IDLE (starvation override still applies). Undefined: fixed CPU priority.
module data_mem_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned STARVE_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [2:0]       cpu_mode,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic             cpu_stall,
  output logic [WIDTH-1:0] cpu_rdata,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [WIDTH-1:0] dbg_addr,
  input  logic [LEN_W-1:0] dbg_len,
  input  logic [WIDTH-1:0] dbg_wdata,
  output logic             dbg_gnt,
  output logic             dbg_beat,
  output logic             dbg_rvalid,
  output logic [WIDTH-1:0] dbg_rdata,
  output logic             dbg_done,
  output logic             dbg_err,
  output logic             mem_we,
  output logic [2:0]       mem_mode,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WRAP_W = 17;
  localparam logic [2:0]  MODE_WORD = 3'b001;

  typedef enum logic {IDLE, DBG_BURST} state_t;

  state_t             state;
  logic [WIDTH-1:0]   addr_q;
  logic [LEN_W-1:0]   rem_q;
  logic               we_q;
  logic [CNT_W-1:0]   starve_cnt;

  logic               dbg_aligned;
  logic               starved;
  logic               dbg_turn;
  logic               cpu_gnt;
  logic               beat_we;
  logic               last_beat;
  logic [WIDTH-1:0]   next_addr;

`ifdef ARB_ROUND_ROBIN_EN
  logic               last_cpu;
`endif

  // Arbitration and memory bus mux
  always_comb begin
    dbg_aligned = (dbg_addr[1:0] == 2'b00);
    starved     = (starve_cnt == CNT_W'(STARVE_MAX));
`ifdef ARB_ROUND_ROBIN_EN
    dbg_turn    = starved | last_cpu;
`else
    dbg_turn    = starved;
`endif
    cpu_gnt   = 1'b0;
    dbg_gnt   = 1'b0;
    dbg_beat  = 1'b0;
    beat_we   = 1'b0;
    last_beat = 1'b0;
    mem_we    = 1'b0;
    mem_mode  = MODE_WORD;
    mem_addr  = '0;
    mem_wd    = '0;

    if (state == IDLE) begin
      if (dbg_req && dbg_aligned && (!cpu_req || dbg_turn)) begin
        dbg_gnt   = 1'b1;
        dbg_beat  = 1'b1;
        beat_we   = dbg_we;
        mem_addr  = dbg_addr;
        last_beat = (dbg_len == '0);
      end else if (cpu_req) begin
        cpu_gnt  = 1'b1;
        mem_we   = cpu_we;
        mem_mode = cpu_mode;
        mem_addr = cpu_addr;
        mem_wd   = cpu_wdata;
      end
    end else begin
      dbg_beat  = 1'b1;
      beat_we   = we_q;
      mem_addr  = addr_q;
      last_beat = (rem_q == LEN_W'(1));
    end

    if (dbg_beat) begin
      mem_we   = beat_we;
      mem_mode = MODE_WORD;
      mem_wd   = dbg_wdata;
    end

    cpu_stall = cpu_req & ~cpu_gnt;
    cpu_rdata = cpu_gnt ? mem_rd : '0;

    // Only the low 17 bits advance; the upper bits stay pinned to the base
    next_addr = {mem_addr[WIDTH-1:WRAP_W], mem_addr[WRAP_W-1:0] + WRAP_W'(4)};
  end

  // State, burst bookkeeping and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      we_q       <= 1'b0;
      starve_cnt <= '0;
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
      dbg_done   <= 1'b0;
      dbg_err    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_cpu   <= 1'b0;
`endif
    end else begin
      dbg_rvalid <= dbg_beat & ~beat_we;
      if (dbg_beat && !beat_we) dbg_rdata <= mem_rd;
      dbg_done   <= dbg_beat & last_beat;
      dbg_err    <= (state == IDLE) & dbg_req & ~dbg_aligned;

      if (dbg_gnt || !dbg_req)  starve_cnt <= '0;
      else if (!starved)        starve_cnt <= starve_cnt + CNT_W'(1);

      if (dbg_beat) addr_q <= next_addr;

`ifdef ARB_ROUND_ROBIN_EN
      if (cpu_gnt)      last_cpu <= 1'b1;
      else if (dbg_gnt) last_cpu <= 1'b0;
`endif

      case (state)
        IDLE: begin
          if (dbg_gnt) begin
            we_q  <= dbg_we;
            rem_q <= dbg_len;
            if (dbg_len != '0) state <= DBG_BURST;
          end
        end
        DBG_BURST: begin
          rem_q <= rem_q - LEN_W'(1);
          if (last_beat) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
